// File: rtl/chnl_echo_pkg.sv
// Shared types for the RIFFA channel echo endpoint: FSM encoding, payload modes, lane math.
package chnl_echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_PREP = 2'd2,
    ST_TX   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ECHO  = 2'd0;
  localparam logic [1:0] MODE_LAST  = 2'd1;
  localparam logic [1:0] MODE_SUM   = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

  function automatic int lane_count(input int width);
    return width / 32;
  endfunction

endpackage

// File: rtl/chnl_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry; writes to a full
// FIFO and reads from an empty one are ignored; clr empties it synchronously.
module chnl_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full && !clr;
  assign do_rd   = rd_en && !empty && !clr;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/chnl_echo_fifo.sv
// RIFFA channel test endpoint: buffers one RX transaction, then answers with one TX transaction
// whose payload is an echo, the last beat, a 32-bit word checksum or the word count.
module chnl_echo_fifo
  import chnl_echo_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH     = 512
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [1:0]                  MODE,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_ACK,
  output logic                        CHNL_RX_DATA_REN,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_ACK,
  input  logic                        CHNL_TX_DATA_REN,
  output logic                        OVERFLOW,
  output logic [15:0]                 TXN_COUNT
);
  localparam int W  = C_PCI_DATA_WIDTH;
  localparam int L  = lane_count(C_PCI_DATA_WIDTH);
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

  state_t          state, state_nxt;
  logic [31:0]     len_q;
  logic [1:0]      mode_q;
  logic [32:0]     rcount, rcount_nxt;
  logic [31:0]     sum_q, beat_sum;
  logic [W-1:0]    last_q, payload_q, fifo_rd_data;
  logic [31:0]     tx_len_q;
  logic [CW-1:0]   beats_left, prep_beats, fifo_count;
  logic            overflow_q;
  logic [15:0]     txn_q;
  logic            rx_fire, tx_fire, fifo_wr, fifo_rd, fifo_clr, fifo_full;
  logic            fifo_empty_unused;
  logic            unused_inputs;

  assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF, CHNL_TX_ACK};

  assign CHNL_RX_CLK = CLK;
  assign CHNL_TX_CLK = CLK;
  assign OVERFLOW    = overflow_q;
  assign TXN_COUNT   = txn_q;

  assign rx_fire    = (state == ST_RX) && CHNL_RX_DATA_VALID;
  assign tx_fire    = (state == ST_TX) && CHNL_TX_DATA_REN;
  assign rcount_nxt = rcount + (rx_fire ? 33'(L) : 33'd0);
  assign fifo_wr    = rx_fire && (mode_q == MODE_ECHO);
  assign fifo_rd    = tx_fire && (mode_q == MODE_ECHO);
  assign fifo_clr   = (state == ST_IDLE) && CHNL_RX;
  assign prep_beats = (mode_q == MODE_ECHO) ? fifo_count : CW'(1);

  // Only lanes whose global word index is below the requested length join the sum.
  always_comb begin
    beat_sum = sum_q;
    for (int i = 0; i < L; i++) begin
      if (rcount + 33'(i) < {1'b0, len_q}) beat_sum = beat_sum + CHNL_RX_DATA[32*i +: 32];
    end
  end

  chnl_sync_fifo #(.WIDTH(W), .DEPTH(C_FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (CHNL_RX_DATA),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty_unused),
    .count   (fifo_count)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    CHNL_RX_ACK        = 1'b0;
    CHNL_RX_DATA_REN   = 1'b0;
    CHNL_TX            = 1'b0;
    CHNL_TX_LAST       = 1'b0;
    CHNL_TX_LEN        = 32'd0;
    CHNL_TX_OFF        = 31'd0;
    CHNL_TX_DATA       = '0;
    CHNL_TX_DATA_VALID = 1'b0;
    case (state)
      ST_IDLE: if (CHNL_RX) state_nxt = ST_RX;
      ST_RX: begin
        CHNL_RX_ACK      = 1'b1;
        CHNL_RX_DATA_REN = 1'b1;
        if (rcount_nxt >= {1'b0, len_q}) state_nxt = ST_PREP;
      end
      ST_PREP: state_nxt = (prep_beats == '0) ? ST_IDLE : ST_TX;
      ST_TX: begin
        CHNL_TX            = 1'b1;
        CHNL_TX_LAST       = 1'b1;
        CHNL_TX_LEN        = tx_len_q;
        CHNL_TX_DATA       = (mode_q == MODE_ECHO) ? fifo_rd_data : payload_q;
        CHNL_TX_DATA_VALID = 1'b1;
        if (tx_fire && beats_left == CW'(1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q      <= '0;
      mode_q     <= MODE_ECHO;
      rcount     <= '0;
      sum_q      <= '0;
      last_q     <= '0;
      payload_q  <= '0;
      tx_len_q   <= '0;
      beats_left <= '0;
      overflow_q <= 1'b0;
      txn_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (CHNL_RX) begin
          len_q  <= CHNL_RX_LEN;
          mode_q <= MODE;
          rcount <= '0;
          sum_q  <= '0;
        end
        ST_RX: if (rx_fire) begin
          rcount <= rcount_nxt;
          sum_q  <= beat_sum;
          last_q <= CHNL_RX_DATA;
          if (fifo_wr && fifo_full) overflow_q <= 1'b1;
        end
        ST_PREP: begin
          case (mode_q)
            MODE_LAST: payload_q <= last_q;
            MODE_SUM:  payload_q <= W'(sum_q);
            default:   payload_q <= W'(len_q);
          endcase
          tx_len_q   <= 32'(prep_beats) * 32'(L);
          beats_left <= prep_beats;
        end
        ST_TX: if (tx_fire) begin
          beats_left <= beats_left - CW'(1);
          if (beats_left == CW'(1)) txn_q <= txn_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_echo_fifo.sv
// Bench for chnl_echo_fifo (64-bit channel, 4-beat FIFO): directed table plus random transactions
// against a word-level model of the echo / last / checksum / count rules.
`timescale 1ns/1ps
module tb_chnl_echo_fifo;
  import chnl_echo_pkg::*;

  localparam int W     = 64;
  localparam int L     = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          rx_clk, tx_clk;
  logic          rx = 1'b0, rx_last = 1'b0, rx_valid = 1'b0;
  logic [31:0]   rx_len = '0;
  logic [30:0]   rx_off = '0;
  logic [W-1:0]  rx_data = '0;
  logic          rx_ack, rx_ren;
  logic          tx, tx_last, tx_valid;
  logic [31:0]   tx_len;
  logic [30:0]   tx_off;
  logic [W-1:0]  tx_data;
  logic          tx_ack = 1'b0, tx_ren = 1'b0;
  logic          overflow;
  logic [15:0]   txn_count;

  chnl_echo_fifo #(.C_PCI_DATA_WIDTH(W), .C_FIFO_DEPTH(DEPTH)) u_dut (
    .CLK(clk), .RST_N(rst_n), .MODE(mode),
    .CHNL_RX_CLK(rx_clk), .CHNL_RX(rx), .CHNL_RX_LAST(rx_last), .CHNL_RX_LEN(rx_len),
    .CHNL_RX_OFF(rx_off), .CHNL_RX_DATA(rx_data), .CHNL_RX_DATA_VALID(rx_valid),
    .CHNL_RX_ACK(rx_ack), .CHNL_RX_DATA_REN(rx_ren),
    .CHNL_TX_CLK(tx_clk), .CHNL_TX(tx), .CHNL_TX_LAST(tx_last), .CHNL_TX_LEN(tx_len),
    .CHNL_TX_OFF(tx_off), .CHNL_TX_DATA(tx_data), .CHNL_TX_DATA_VALID(tx_valid),
    .CHNL_TX_ACK(tx_ack), .CHNL_TX_DATA_REN(tx_ren),
    .OVERFLOW(overflow), .TXN_COUNT(txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] beats_q[$];
  logic [63:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic [63:0] m_last = '0;
  logic [15:0] m_txn = '0;
  logic [31:0] cap_len;
  logic [31:0] cap_w0;

  typedef struct {
    logic [1:0]   md;
    int           len;
    logic [255:0] pat;
    int           ren_mode;
    int           exp_len;
    logic [31:0]  exp_w0;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] md, input int len, input logic [255:0] pat,
                              input int ren_mode, input int exp_len, input logic [31:0] exp_w0,
                              input logic exp_ovf);
    vec_t v;
    v.md = md; v.len = len; v.pat = pat; v.ren_mode = ren_mode;
    v.exp_len = exp_len; v.exp_w0 = exp_w0; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  // Word-level view: the RX payload is a flat list of 32-bit words, word k in beat k/L, lane k%L.
  task automatic model(input logic [1:0] md, input int len);
    logic [31:0] sum;
    logic [63:0] b;
    exp_q.delete();
    foreach (beats_q[i]) m_last = beats_q[i];
    case (md)
      MODE_ECHO: begin
        for (int i = 0; i < beats_q.size() && i < DEPTH; i++) exp_q.push_back(beats_q[i]);
        if (beats_q.size() > DEPTH) m_ovf = 1'b1;
      end
      MODE_LAST: exp_q.push_back(m_last);
      MODE_SUM: begin
        sum = '0;
        for (int k = 0; k < len; k++) begin
          b = beats_q[k / L];
          sum = sum + b[(k % L) * 32 +: 32];
        end
        exp_q.push_back({32'd0, sum});
      end
      default: exp_q.push_back({32'd0, 32'(len)});
    endcase
    if (exp_q.size() > 0) m_txn = m_txn + 16'd1;
  endtask

  task automatic send_rx(input logic [1:0] md, input int len, input bit gaps);
    bit ok;
    @(negedge clk);
    mode = md; rx_len = 32'(len); rx = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (rx_ack) ok = 1'b1;
    end
    chk("rx_ack", 64'(ok), 64'd1);
    chk("rx_ren", 64'(rx_ren), 64'd1);
    rx = 1'b0;
    mode = ~md;
    if (beats_q.size() == 0) @(negedge clk);
    foreach (beats_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      rx_data = beats_q[i]; rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_data = '0;
  endtask

  // ren_mode: 0 random, 1 alternating 1/0, 2 always ready.
  task automatic recv_tx(input int ren_mode);
    logic [63:0] got[$];
    logic [63:0] held;
    bit seen, stalled, tog, any;
    int n;
    n = exp_q.size();
    seen = 1'b0; stalled = 1'b0; tog = 1'b1; held = '0;
    cap_len = '0; cap_w0 = '0;
    if (n == 0) begin
      any = 1'b0;
      repeat (6) begin
        @(negedge clk);
        any = any | tx | tx_valid;
      end
      chk("no_tx", 64'(any), 64'd0);
    end else begin
      for (int c = 0; c < 200 && got.size() < n; c++) begin
        case (ren_mode)
          0:       tx_ren = ($urandom_range(0, 3) != 0);
          1:       begin tx_ren = tog; tog = ~tog; end
          default: tx_ren = 1'b1;
        endcase
        if (seen) chk("tx_valid_hold", 64'(tx_valid), 64'd1);
        if (tx_valid) begin
          if (!seen) begin
            seen = 1'b1;
            cap_len = tx_len; cap_w0 = tx_data[31:0];
            chk("tx_first_cycle", 64'(c), 64'd1);
            chk("tx_len", 64'(tx_len), 64'(n * L));
            chk("tx_flags", 64'({tx, tx_last, tx_off}), 64'({1'b1, 1'b1, 31'd0}));
          end
          if (stalled) chk("tx_stall_hold", tx_data, held);
          if (tx_ren) begin
            got.push_back(tx_data); stalled = 1'b0;
          end else begin
            stalled = 1'b1; held = tx_data;
          end
        end
        @(negedge clk);
      end
      tx_ren = 1'b0;
      chk("tx_beats", 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++) chk("tx_data", got[i], exp_q[i]);
    end
    chk("tx_idle", 64'(tx), 64'd0);
    chk("txn_count", 64'(txn_count), 64'(m_txn));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic run_vec(input vec_t v);
    logic [255:0] pat;
    pat = v.pat;
    beats_q.delete();
    for (int i = 0; i < (v.len + L - 1) / L; i++) beats_q.push_back(pat[(i % 4) * 64 +: 64]);
    model(v.md, v.len);
    send_rx(v.md, v.len, 1'b0);
    recv_tx(v.ren_mode);
    if (v.exp_len > 0) begin
      chk("tbl_len", 64'(cap_len), 64'(v.exp_len));
      chk("tbl_w0", 64'(cap_w0), 64'(v.exp_w0));
    end
    chk("tbl_ovf", 64'(overflow), 64'(v.exp_ovf));
  endtask

  initial begin
    logic [255:0] p1234, psum;
    bit ok;
    p1234 = {64'h4, 64'h3, 64'h2, 64'h1};
    psum  = {64'h0, 64'h0, {32'h0000DEAD, 32'h5}, {32'h2, 32'hFFFFFFFF}};
    tbl[0] = mk(MODE_ECHO,  8,  p1234, 1, 8, 32'h1, 1'b0);
    tbl[1] = mk(MODE_SUM,   3,  psum,  0, 2, 32'h6, 1'b0);
    tbl[2] = mk(MODE_COUNT, 0,  p1234, 2, 2, 32'h0, 1'b0);
    tbl[3] = mk(MODE_ECHO,  0,  p1234, 0, 0, 32'h0, 1'b0);
    tbl[4] = mk(MODE_LAST,  5,  p1234, 0, 2, 32'h3, 1'b0);
    tbl[5] = mk(MODE_COUNT, 7,  p1234, 2, 2, 32'h7, 1'b0);
    tbl[6] = mk(MODE_ECHO,  7,  p1234, 0, 8, 32'h1, 1'b0);
    tbl[7] = mk(MODE_ECHO,  12, p1234, 0, 8, 32'h1, 1'b1);

    #3;
    chk("rst_tx", 64'({tx, tx_last, tx_valid, tx_len, tx_off}), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_rx", 64'({rx_ack, rx_ren}), 64'd0);
    chk("rst_status", 64'({overflow, txn_count}), 64'd0);
    @(posedge clk); #1;
    chk("clk_fwd", 64'({rx_clk, tx_clk}), 64'b11);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Abort an echo mid-TX with a stalled beat pending.
    beats_q.delete();
    for (int i = 0; i < 4; i++) beats_q.push_back(64'hA0 + 64'(i));
    send_rx(MODE_ECHO, 8, 1'b0);
    tx_ren = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      if (tx_valid) ok = 1'b1;
      @(negedge clk);
    end
    chk("abort_tx_started", 64'(ok), 64'd1);
    tx_ren = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", 64'({tx, tx_last, tx_valid, tx_len, tx_off}), 64'd0);
    chk("abort_tx_data", tx_data, 64'd0);
    chk("abort_rx", 64'({rx_ack, rx_ren}), 64'd0);
    chk("abort_status", 64'({overflow, txn_count}), 64'd0);
    m_ovf = 1'b0; m_last = '0; m_txn = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[0]);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] md;
      int len;
      md  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 11);
      beats_q.delete();
      for (int i = 0; i < (len + L - 1) / L; i++) beats_q.push_back({$urandom, $urandom});
      model(md, len);
      send_rx(md, len, 1'b1);
      recv_tx(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chnl_echo_fifo.md
# chnl_echo_fifo

Parametrised RIFFA channel test endpoint, the successor to the single-register channel tester. It receives one RX transaction into an on-chip FIFO, then answers with one TX transaction. The TX payload is set by a per-transaction mode: full echo, last beat, 32-bit checksum, or word count. It sits directly on one RIFFA channel's CHNL_* bus and is used for link bring-up and throughput/integrity testing.

## Interface
- C_PCI_DATA_WIDTH, 32: channel data width in bits; one of 32/64/128. `L = C_PCI_DATA_WIDTH/32` lanes per beat.
- C_FIFO_DEPTH, 512: FIFO depth in beats; power of two, at least 4.
- CLK  in  1  sole clock. All CHNL_* clocks are driven from it.
- RST_N  in  1  reset, asynchronous assert, active-low.
- MODE  in  2  payload select, sampled when a transaction is accepted: 0 echo, 1 last beat, 2 checksum, 3 count.
- CHNL_RX_CLK  out  1  = CLK.
- CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN[31:0], CHNL_RX_OFF[30:0], CHNL_RX_DATA[W-1:0], CHNL_RX_DATA_VALID  in  RIFFA RX inputs.
- CHNL_RX_ACK, CHNL_RX_DATA_REN  out  1  RIFFA RX handshakes.
- CHNL_TX_CLK  out  1  = CLK.
- CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN[31:0], CHNL_TX_OFF[30:0], CHNL_TX_DATA[W-1:0], CHNL_TX_DATA_VALID  out  RIFFA TX outputs.
- CHNL_TX_ACK, CHNL_TX_DATA_REN  in  1  RIFFA TX handshakes.
- OVERFLOW  out  1  sticky: an echo RX exceeded FIFO capacity. Cleared only by reset.
- TXN_COUNT  out  16  completed TX transactions; wraps at 65535 -> 0.

## Operation
- States: IDLE, RX, PREP, TX.
- IDLE -> RX when CHNL_RX=1.
  - Latch rLen <= CHNL_RX_LEN and mode <= MODE.
  - Clear rCount, the sum, and the FIFO.
- RX:
  - CHNL_RX_ACK=1 and CHNL_RX_DATA_REN=1.
  - Each beat with VALID does rCount += L.
  - Echo mode writes the beat to the FIFO while it is not full. Beats arriving when full are dropped and set OVERFLOW; REN stays high regardless.
  - Every beat updates the last-beat register.
  - Checksum = 32-bit wraparound sum of the lanes with index < rLen. Padding lanes of the final beat are excluded.
  - RX -> PREP when rCount >= rLen, checked after the update. rLen=0 leaves RX on the first cycle.
- PREP: compute the TX length in 32-bit words.
  - Echo: stored beats × L.
  - Last beat: L.
  - Checksum / count: L, payload in lane 0, upper lanes zero. Count payload = rLen.
  - PREP -> TX, or PREP -> IDLE if the length is 0 (echo with no beats; TXN_COUNT unchanged).
- TX:
  - CHNL_TX=1, CHNL_TX_LAST=1, CHNL_TX_OFF=0, CHNL_TX_LEN held constant.
  - DATA_VALID=1 whenever an output beat is staged.
  - A beat transfers on VALID & REN. CHNL_TX_ACK is accepted but not required to advance.
  - After the last beat transfers: TXN_COUNT += 1, TX -> IDLE.
- CHNL_RX deasserting mid-RX has no effect; rLen governs.
- A new CHNL_RX while in PREP/TX waits in IDLE's sense: it is not acked until the state returns to IDLE.

## Timing
- Reset values: state IDLE; all CHNL_* outputs 0 except CHNL_RX_CLK/CHNL_TX_CLK; OVERFLOW 0; TXN_COUNT 0; FIFO empty.
- CHNL_RX_ACK/REN rise 1 cycle after the CHNL_RX sample edge.
- RX data is written to the FIFO on the same edge it is accepted.
- PREP lasts exactly 1 cycle.
- CHNL_TX rises on entry to TX. The first DATA_VALID occurs in the same cycle: the FIFO is show-ahead and primed during PREP.
- Consecutive beats transfer on back-to-back cycles while REN=1. No bubbles are allowed.
- TX data must be stable while VALID=1 and REN=0.
- Minimum turnaround for a 1-beat payload: CHNL_RX high -> CHNL_TX high = RX cycles + 2.
- Reset asserted mid-transaction aborts immediately. All outputs reach their reset values asynchronously; the FIFO contents are discarded.

## Structure
- Package chnl_echo_pkg holds:
  - state encoding (IDLE=0, RX=1, PREP=2, TX=3);
  - mode constants (MODE_ECHO, MODE_LAST, MODE_SUM, MODE_COUNT);
  - a lane-count function of width.
- Sub-module chnl_sync_fifo: single-clock, show-ahead, parametrised width/depth, with full/empty outputs, a beat-count output, and a synchronous clear.

## Test plan
- W=64, MODE=0, RX_LEN=8, 4 beats 0x1..0x4 -> TX_LEN=8; the same 4 beats are returned in order; TXN_COUNT=1.
- W=32, MODE=2, RX_LEN=3, data 0xFFFFFFFF, 0x2, 0x5 -> TX_LEN=1, data 0x00000006.
- W=64, MODE=2, RX_LEN=3 (2 beats), upper lane of beat 2 = 0xDEAD -> 0xDEAD excluded from the sum.
- C_FIFO_DEPTH=4, MODE=0, RX_LEN=6 beats (W=32) -> OVERFLOW=1, TX_LEN=4, first 4 words echoed.
- MODE=3, RX_LEN=0 -> RX exits after 1 cycle; TX_LEN=L, lane 0=0. MODE=0, RX_LEN=0 -> no TX, TXN_COUNT unchanged.
- TX_DATA_REN toggled 1/0 during a 4-beat echo -> data held stable while stalled; RST_N pulsed mid-TX -> all outputs 0 at once, next transaction is clean.
